// File: rtl/dmem_responder.sv
// Single-port data-memory responder: one outstanding load/store, fixed LATENCY, sized/extended loads.
// Optional macro DMEM_MISALIGN_CHECK_EN flags misaligned half/word accesses instead of performing them.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        q_we, q_unsigned;
    logic [1:0]  q_size;
    logic [31:0] q_addr, q_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept, enter_resp, misalign;
    logic        cur_we, cur_unsigned;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr, cur_wdata;
    logic [AW-1:0] idx;
    logic [1:0]  lane;
    logic [31:0] rd_word, load_data, resp_data, wr_lanes;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [3:0]  be;
    logic        unused_addr_bits;

    assign req_ready = (state == IDLE) && reset;
    assign accept    = req_valid && req_ready;

    // With LATENCY=1 the commit happens on the acceptance edge itself, so the live request is used.
    always_comb begin
        if (state == IDLE) begin
            cur_we = req_we;  cur_size = req_size;  cur_unsigned = req_unsigned;
            cur_addr = req_addr;  cur_wdata = req_wdata;
        end else begin
            cur_we = q_we;  cur_size = q_size;  cur_unsigned = q_unsigned;
            cur_addr = q_addr;  cur_wdata = q_wdata;
        end
    end

    assign enter_resp = reset && (((state == IDLE) && accept && (LATENCY == 1)) ||
                                  ((state == WAIT) && (cnt == 4'd0)));
    assign idx  = cur_addr[AW+1:2];
    assign lane = cur_addr[1:0];
    assign unused_addr_bits = ^req_addr[31:AW+2] ^ ^q_addr[31:AW+2];

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = ((cur_size == 2'b01) && cur_addr[0]) ||
                      (cur_size[1] && (cur_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    always_comb begin
        rd_word   = mem[idx];
        rd_byte   = rd_word[{lane, 3'b000} +: 8];
        rd_half   = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        be        = 4'b1111;
        wr_lanes  = cur_wdata;
        case (cur_size)
            2'b00: begin
                load_data = cur_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                be        = 4'b0001 << lane;
                wr_lanes  = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                load_data = cur_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
                be        = cur_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes  = {2{cur_wdata[15:0]}};
            end
            default: ;
        endcase
        resp_data = (cur_we || misalign) ? 32'd0 : load_data;
    end

    // NOTE: the memory array has no reset; contents survive reset and only the control path is cleared.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !misalign) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    // NOTE: all sequential state uses non-blocking '<=' so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    q_we       <= req_we;
                    q_size     <= req_size;
                    q_unsigned <= req_unsigned;
                    q_addr     <= req_addr;
                    q_wdata    <= req_wdata;
                    if (LATENCY == 1) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= resp_data;
                        resp_err   <= misalign;
                    end else begin
                        state <= WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= resp_data;
                        resp_err   <= misalign;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: if (resp_ready) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameters SHALL be: DEPTH_WORDS, 256, number of 32-bit words (power of two, >=4).
REQ-002 Parameters SHALL be: LATENCY, 2, cycles from request acceptance to resp_valid (1..15).
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port reset  in  1  synchronous, active-low reset.
REQ-005 Port req_valid  in  1  core presents a load/store request.
REQ-006 Port req_ready  out  1  responder can accept a request.
REQ-007 Port req_we  in  1  1 = store, 0 = load.
REQ-008 Port req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 Port req_unsigned  in  1  1 = zero-extend load (LBU/LHU), 0 = sign-extend.
REQ-010 Port req_addr  in  32  byte address.
REQ-011 Port req_wdata  in  32  store data, right-justified.
REQ-012 Port resp_valid  out  1  response available.
REQ-013 Port resp_ready  in  1  core consumes response.
REQ-014 Port resp_rdata  out  32  load result, extended per size/unsigned; 0 for stores.
REQ-015 Port resp_err  out  1  misaligned access flag (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, WAIT, RESP; one outstanding request maximum.
REQ-017 req_ready SHALL be 1 only in IDLE with reset high; acceptance = req_valid & req_ready at a rising edge.
REQ-018 On acceptance, we/size/unsigned/addr/wdata SHALL be registered; later changes on req_* are ignored until the next acceptance.
REQ-019 On acceptance: LATENCY=1 -> RESP; else -> WAIT with counter loaded to LATENCY-2, decrementing each cycle, -> RESP at counter 0.
REQ-020 resp_valid SHALL rise exactly LATENCY cycles after the acceptance edge.
REQ-021 The store commit and the load-data capture SHALL occur on the edge entering RESP; a store writes only the enabled byte lanes.
REQ-022 Word index = addr[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (address wraps modulo DEPTH_WORDS*4).
REQ-023 Byte lane = addr[1:0]; half lane = addr[1]; byte/half loads SHALL be extended to 32 bits per req_unsigned.
REQ-024 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_ready=1; at that edge -> IDLE.
REQ-025 A new request SHALL be accepted no earlier than the cycle after the RESP handshake (minimum period LATENCY+2 cycles).
REQ-026 resp_rdata SHALL be 0 whenever resp_valid=0 and for every store response.

Reset
REQ-027 While reset=0 at an edge: state->IDLE, counter->0, resp_valid->0, resp_rdata->0, resp_err->0; req_ready reads 0 while reset=0.
REQ-028 Reset asserted in WAIT or RESP SHALL abort the request: the pending store is discarded and no response is issued.
REQ-029 Memory array contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro DMEM_MISALIGN_CHECK_EN: when defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL produce resp_err=1, resp_rdata=0, no write, same latency.
REQ-031 Without DMEM_MISALIGN_CHECK_EN: resp_err SHALL be tied 0; the half access uses addr[1] only, the word access ignores addr[1:0], and the access is performed.

Verification
REQ-032 reset=0 for 2 cycles, then 1 -> req_ready=1, resp_valid=0, resp_rdata=0 in the first cycle after release.
REQ-033 LATENCY=2: SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_valid exactly 2 cycles after each accept; LW rdata=0xDEADBEEF.
REQ-034 After word 0x80FF7F01 @0x20: LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080; LH @0x20 -> 0x00007F01; LHU @0x22 -> 0x000080FF.
REQ-035 SB 0xAA @0x21 over 0x11223344 -> LW returns 0x1122AA44; store @ 0x400+0x21 with DEPTH_WORDS=256 aliases to @0x21.
REQ-036 Hold resp_ready=0 for 5 cycles in RESP -> outputs stable and req_ready=0 throughout; resp_ready=1 -> IDLE the next cycle.
REQ-037 With macro: LW @0x22 -> resp_err=1, rdata=0, memory unchanged. Reset in WAIT during a store -> no resp_valid, location unchanged.
